// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and default constants for the instruction fetch
//               stage: FSM state encoding, default widths / reset PC and the
//               queue entry layout {pc, instr}.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int         C_ADDR_W   = 8;
    localparam int         C_INSTR_W  = 16;
    localparam logic [7:0] C_RESET_PC = 8'h00;

    typedef enum logic [1:0] {
        RST_HOLD = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RSP = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [C_ADDR_W-1:0]  pc;
        logic [C_INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit_if
// Description : Bundles every non-clock/reset signal of the fetch stage.
//               master : the fetch unit (drives pc_next, imem request, out_*)
//               slave  : the surroundings (PC register, imem, execute, decode)
//               Signals: pc_in/pc_next, imem_req_{valid,addr,ready},
//               imem_rsp_{valid,data}, redirect_{valid,target},
//               out_{valid,pc,instr,ready}.
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_unit_if
    import fetch_pkg::*;
#(
    parameter int ADDR_W  = C_ADDR_W,
    parameter int INSTR_W = C_INSTR_W
) ();

    logic [ADDR_W-1:0]  pc_in;
    logic [ADDR_W-1:0]  pc_next;

    logic               imem_req_valid;
    logic [ADDR_W-1:0]  imem_req_addr;
    logic               imem_req_ready;
    logic               imem_rsp_valid;
    logic [INSTR_W-1:0] imem_rsp_data;

    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_target;

    logic               out_valid;
    logic [ADDR_W-1:0]  out_pc;
    logic [INSTR_W-1:0] out_instr;
    logic               out_ready;

    modport master (
        input  pc_in,
        output pc_next,
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data,
        input  redirect_valid,
        input  redirect_target,
        output out_valid,
        output out_pc,
        output out_instr,
        input  out_ready
    );

    modport slave (
        output pc_in,
        input  pc_next,
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data,
        output redirect_valid,
        output redirect_target,
        input  out_valid,
        input  out_pc,
        input  out_instr,
        output out_ready
    );

endinterface
`default_nettype wire

// File: rtl/fetch_queue2.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue2
// Description : 2-entry first-word-fall-through queue with synchronous clear.
//               Ports: clk, rst (async, active-high), clr, push/push_data,
//               pop, head (entry at the front), count (0..2), valid.
//               Entry 0 is always the head; a pop shifts entry 1 forward.
//               The head register is left untouched when the queue drains,
//               so the head output holds its last value while empty.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue2
    import fetch_pkg::*;
#(
    parameter type ENTRY_T = fetch_entry_t
) (
    input  wire logic   clk,
    input  wire logic   rst,
    input  wire logic   clr,
    input  wire logic   push,
    input  wire ENTRY_T push_data,
    input  wire logic   pop,
    output ENTRY_T      head,
    output logic [1:0]  count,
    output logic        valid
);

    ENTRY_T     r_ent0;
    ENTRY_T     r_ent1;
    logic [1:0] r_count;
    logic       w_pop;
    logic       w_push;

    // A pop on an empty queue, or a push into a full queue that is not
    // popping at the same time, is ignored.
    assign w_pop  = pop & (r_count != 2'd0);
    assign w_push = push & ((r_count != 2'd2) | w_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ent0  <= '0;
            r_ent1  <= '0;
            r_count <= 2'd0;
        end else if (clr) begin
            // Clear wins over any same-cycle push or pop.
            r_count <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_ent0 <= push_data;
                    end else begin
                        r_ent1 <= push_data;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    if (r_count == 2'd2) begin
                        r_ent0 <= r_ent1;
                    end
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd2) begin
                        r_ent0 <= r_ent1;
                        r_ent1 <= push_data;
                    end else begin
                        r_ent0 <= push_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign head  = r_ent0;
    assign count = r_count;
    assign valid = (r_count != 2'd0);

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch stage between the PC register and decode.
//               Computes pc_next every cycle, issues one imem read at a time,
//               buffers responses in a 2-entry queue toward decode and
//               handles redirects from execute (dropping a stale in-flight
//               response when needed).
//               Ports: clk, rst (async, active-high), bus (fetch_unit_if
//               master modport).
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = C_ADDR_W,
    parameter int                INSTR_W  = C_INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(C_RESET_PC)
) (
    input  wire logic    clk,
    input  wire logic    rst,
    fetch_unit_if.master bus
);

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    fetch_state_e      r_state;
    logic [ADDR_W-1:0] r_req_pc;
    logic              r_drop;

    logic              w_redirect;
    logic              w_req_valid;
    logic              w_hs;
    logic              w_push;
    logic              w_pop;
    logic [ADDR_W-1:0] w_pc_next;
    entry_t            w_push_data;
    entry_t            w_head;
    logic [1:0]        w_count;
    logic              w_q_valid;

    // Redirects are meaningless while the PC is still being forced to reset.
    assign w_redirect = bus.redirect_valid & (r_state != RST_HOLD);

    // Registered occupancy gates the request, so decode's out_ready has no
    // combinational path to the memory request. Requesting only with a free
    // slot reserves room for the response before it comes back.
    assign w_req_valid = (r_state == ISSUE) & (w_count != 2'd2) & ~bus.redirect_valid;
    assign w_hs        = w_req_valid & bus.imem_req_ready;

    assign w_push             = (r_state == WAIT_RSP) & bus.imem_rsp_valid & ~r_drop;
    assign w_push_data.pc     = r_req_pc;
    assign w_push_data.instr  = bus.imem_rsp_data;
    assign w_pop              = w_q_valid & bus.out_ready;

    always_comb begin
        w_pc_next = bus.pc_in;
        if (r_state == RST_HOLD) begin
            w_pc_next = RESET_PC;
        end else if (bus.redirect_valid) begin
            w_pc_next = bus.redirect_target;
        end else if (w_hs) begin
            w_pc_next = bus.pc_in + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= RST_HOLD;
            r_req_pc <= '0;
            r_drop   <= 1'b0;
        end else begin
            case (r_state)
                RST_HOLD: begin
                    r_state <= ISSUE;
                end
                ISSUE: begin
                    if (w_hs) begin
                        r_req_pc <= bus.pc_in;
                        r_state  <= WAIT_RSP;
                    end
                end
                WAIT_RSP: begin
                    // Any response retires the outstanding request: it is
                    // either pushed, or it is the stale one that drop marks.
                    // A same-cycle redirect voids the push through the clear.
                    if (bus.imem_rsp_valid) begin
                        r_drop  <= 1'b0;
                        r_state <= ISSUE;
                    end else if (w_redirect) begin
                        r_drop <= 1'b1;
                    end
                end
                default: begin
                    r_state <= RST_HOLD;
                end
            endcase
        end
    end

    fetch_queue2 #(
        .ENTRY_T (entry_t)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .clr       (w_redirect),
        .push      (w_push),
        .push_data (w_push_data),
        .pop       (w_pop),
        .head      (w_head),
        .count     (w_count),
        .valid     (w_q_valid)
    );

    assign bus.pc_next        = w_pc_next;
    assign bus.imem_req_valid = w_req_valid;
    assign bus.imem_req_addr  = bus.pc_in;
    assign bus.out_valid      = w_q_valid;
    assign bus.out_pc         = w_head.pc;
    assign bus.out_instr      = w_head.instr;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Directed self-checking bench for fetch_unit. DUT A
//               (RESET_PC=00) runs the directed scenarios; DUT B
//               (RESET_PC=FE) free-runs with a 1-cycle memory to show PC
//               wrap-around. Each memory returns addr*3.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fetch_unit;
    import fetch_pkg::*;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic rst_b = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    fetch_unit_if #(.ADDR_W(8), .INSTR_W(16)) ifa ();
    fetch_unit_if #(.ADDR_W(8), .INSTR_W(16)) ifb ();

    fetch_unit #(.ADDR_W(8), .INSTR_W(16), .RESET_PC(8'h00)) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    fetch_unit #(.ADDR_W(8), .INSTR_W(16), .RESET_PC(8'hFE)) u_dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (ifb)
    );

    // Program counter registers: load pc_next every edge.
    logic [7:0] pc_a;
    logic [7:0] pc_b;
    always @(posedge clk) pc_a <= ifa.pc_next;
    always @(posedge clk) pc_b <= ifb.pc_next;
    assign ifa.pc_in = pc_a;
    assign ifb.pc_in = pc_b;

    // Memory A: fixed latency lat_a, always ready.
    int         lat_a;
    int         cnt_a   = 0;
    logic [7:0] raddr_a = 8'h00;
    always @(posedge clk) begin
        if (ifa.imem_req_valid && ifa.imem_req_ready) begin
            cnt_a   <= lat_a;
            raddr_a <= ifa.imem_req_addr;
        end else if (cnt_a != 0) begin
            cnt_a <= cnt_a - 1;
        end
    end
    assign ifa.imem_req_ready = 1'b1;
    assign ifa.imem_rsp_valid = (cnt_a == 1);
    assign ifa.imem_rsp_data  = 16'(raddr_a) * 16'd3;

    // Memory B: 1-cycle latency.
    logic       rv_b    = 1'b0;
    logic [7:0] raddr_b = 8'h00;
    always @(posedge clk) begin
        rv_b <= ifb.imem_req_valid & ifb.imem_req_ready;
        if (ifb.imem_req_valid && ifb.imem_req_ready) raddr_b <= ifb.imem_req_addr;
    end
    assign ifb.imem_req_ready  = 1'b1;
    assign ifb.imem_rsp_valid  = rv_b;
    assign ifb.imem_rsp_data   = 16'(raddr_b) * 16'd3;
    assign ifb.redirect_valid  = 1'b0;
    assign ifb.redirect_target = 8'h00;
    assign ifb.out_ready       = 1'b1;

    // Record the first outputs of DUT B.
    logic [7:0]  seqb_pc    [0:7];
    logic [15:0] seqb_instr [0:7];
    int          nb = 0;
    always @(posedge clk) begin
        if (ifb.out_valid && nb < 8) begin
            seqb_pc[nb[2:0]]    <= ifb.out_pc;
            seqb_instr[nb[2:0]] <= ifb.out_instr;
            nb                  <= nb + 1;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Two edges with rst high, then release: returns in the RST_HOLD cycle.
    task automatic do_reset();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic wait_out(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (ifa.out_valid === 1'b1) break;
            cyc();
        end
        chk(tag, 32'(ifa.out_valid), 32'h1);
    endtask

    initial begin
        bit found;
        ifa.redirect_valid  = 1'b0;
        ifa.redirect_target = 8'h00;
        ifa.out_ready       = 1'b1;
        lat_a               = 1;

        // ---- reset values ----
        #2;
        chk("rst_out_valid", 32'(ifa.out_valid), 32'h0);
        chk("rst_out_pc", 32'(ifa.out_pc), 32'h00);
        chk("rst_out_instr", 32'(ifa.out_instr), 32'h0000);
        chk("rst_req_valid", 32'(ifa.imem_req_valid), 32'h0);
        chk("rst_pc_next", 32'(ifa.pc_next), 32'h00);
        chk("rst_pc_next_b", 32'(ifb.pc_next), 32'hFE);
        cyc();
        cyc();
        rst   = 1'b0;
        rst_b = 1'b0;

        // ---- 1-cycle memory streaming ----
        chk("hold_req_valid", 32'(ifa.imem_req_valid), 32'h0);
        chk("hold_pc_next", 32'(ifa.pc_next), 32'h00);
        cyc();
        chk("t1_req_valid", 32'(ifa.imem_req_valid), 32'h1);
        chk("t1_req_addr", 32'(ifa.imem_req_addr), 32'h00);
        chk("t1_pc_next", 32'(ifa.pc_next), 32'h01);
        cyc();
        chk("t1_wait_out_valid", 32'(ifa.out_valid), 32'h0);
        chk("t1_wait_req_valid", 32'(ifa.imem_req_valid), 32'h0);
        cyc();
        chk("t1_out0_valid", 32'(ifa.out_valid), 32'h1);
        chk("t1_out0_pc", 32'(ifa.out_pc), 32'h00);
        chk("t1_out0_instr", 32'(ifa.out_instr), 32'h0000);
        cyc();
        chk("t1_gap_valid", 32'(ifa.out_valid), 32'h0);
        cyc();
        chk("t1_out1_pc", 32'(ifa.out_pc), 32'h01);
        chk("t1_out1_instr", 32'(ifa.out_instr), 32'h0003);
        cyc();
        cyc();
        chk("t1_out2_valid", 32'(ifa.out_valid), 32'h1);
        chk("t1_out2_pc", 32'(ifa.out_pc), 32'h02);
        chk("t1_out2_instr", 32'(ifa.out_instr), 32'h0006);

        // ---- backpressure ----
        ifa.out_ready = 1'b0;
        do_reset();
        repeat (5) cyc();
        chk("t2_full_req_valid", 32'(ifa.imem_req_valid), 32'h0);
        chk("t2_full_pc_next", 32'(ifa.pc_next), 32'h02);
        chk("t2_full_pc_in", 32'(ifa.imem_req_addr), 32'h02);
        chk("t2_full_out_pc", 32'(ifa.out_pc), 32'h00);
        cyc();
        chk("t2_full_req_valid2", 32'(ifa.imem_req_valid), 32'h0);
        ifa.out_ready = 1'b1;
        #1;
        chk("t2_pop_out_pc", 32'(ifa.out_pc), 32'h00);
        cyc();
        chk("t2_after_out_pc", 32'(ifa.out_pc), 32'h01);
        chk("t2_after_out_instr", 32'(ifa.out_instr), 32'h0003);
        chk("t2_after_req_valid", 32'(ifa.imem_req_valid), 32'h1);
        chk("t2_after_req_addr", 32'(ifa.imem_req_addr), 32'h02);
        chk("t2_after_pc_next", 32'(ifa.pc_next), 32'h03);

        // ---- redirect with response, same cycle as an out handshake ----
        ifa.out_ready = 1'b0;
        do_reset();
        repeat (3) cyc();
        chk("t4_pre_out_pc", 32'(ifa.out_pc), 32'h00);
        chk("t4_pre_out_valid", 32'(ifa.out_valid), 32'h1);
        cyc();
        ifa.out_ready       = 1'b1;
        ifa.redirect_valid  = 1'b1;
        ifa.redirect_target = 8'h80;
        #1;
        chk("t4_redir_pc_next", 32'(ifa.pc_next), 32'h80);
        cyc();
        ifa.redirect_valid = 1'b0;
        #1;
        chk("t4_post_out_valid", 32'(ifa.out_valid), 32'h0);
        chk("t4_post_req_valid", 32'(ifa.imem_req_valid), 32'h1);
        chk("t4_post_req_addr", 32'(ifa.imem_req_addr), 32'h80);
        chk("t4_post_pc_next", 32'(ifa.pc_next), 32'h81);
        cyc();
        cyc();
        chk("t4_out_valid", 32'(ifa.out_valid), 32'h1);
        chk("t4_out_pc", 32'(ifa.out_pc), 32'h80);
        chk("t4_out_instr", 32'(ifa.out_instr), 32'h0180);

        // ---- 3-cycle memory, redirect while pc 05 outstanding ----
        ifa.out_ready = 1'b1;
        lat_a         = 3;
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (ifa.imem_req_valid === 1'b1 && ifa.imem_req_addr === 8'h05) begin
                found = 1'b1;
                break;
            end
            cyc();
        end
        chk("t3_found_req05", 32'(found), 32'h1);
        cyc();
        ifa.redirect_valid  = 1'b1;
        ifa.redirect_target = 8'h40;
        #1;
        chk("t3_redir_pc_next", 32'(ifa.pc_next), 32'h40);
        chk("t3_redir_req_valid", 32'(ifa.imem_req_valid), 32'h0);
        cyc();
        ifa.redirect_valid = 1'b0;
        #1;
        wait_out("t3_out_seen", 20);
        chk("t3_out_pc", 32'(ifa.out_pc), 32'h40);
        chk("t3_out_instr", 32'(ifa.out_instr), 32'h00C0);

        // ---- reset during WAIT_RSP with data queued ----
        ifa.out_ready = 1'b0;
        lat_a         = 3;
        do_reset();
        repeat (6) cyc();
        chk("t6_pre_out_valid", 32'(ifa.out_valid), 32'h1);
        chk("t6_pre_req_valid", 32'(ifa.imem_req_valid), 32'h0);
        rst = 1'b1;
        #1;
        chk("t6_rst_out_valid", 32'(ifa.out_valid), 32'h0);
        chk("t6_rst_pc_next", 32'(ifa.pc_next), 32'h00);
        chk("t6_rst_req_valid", 32'(ifa.imem_req_valid), 32'h0);
        cyc();
        rst = 1'b0;
        cyc();
        chk("t6_late_rsp_req_valid", 32'(ifa.imem_req_valid), 32'h1);
        chk("t6_late_rsp_req_addr", 32'(ifa.imem_req_addr), 32'h00);
        cyc();
        chk("t6_no_stale_out", 32'(ifa.out_valid), 32'h0);
        wait_out("t6_out_seen", 10);
        chk("t6_out_pc", 32'(ifa.out_pc), 32'h00);
        chk("t6_out_instr", 32'(ifa.out_instr), 32'h0000);

        // ---- RESET_PC = FE wrap-around (DUT B) ----
        chk("t5_count", 32'(nb >= 4), 32'h1);
        chk("t5_pc0", 32'(seqb_pc[0]), 32'hFE);
        chk("t5_pc1", 32'(seqb_pc[1]), 32'hFF);
        chk("t5_pc2", 32'(seqb_pc[2]), 32'h00);
        chk("t5_pc3", 32'(seqb_pc[3]), 32'h01);
        chk("t5_instr0", 32'(seqb_instr[0]), 32'h02FA);
        chk("t5_instr1", 32'(seqb_instr[1]), 32'h02FD);
        chk("t5_instr3", 32'(seqb_instr[3]), 32'h0003);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
